// File: rtl/tilelink_pkg.sv
// TileLink-UL subset used on the pinwheel core data bus: A-channel request,
// D-channel response and the opcodes the bus peripherals decode.
package tilelink_pkg;

    localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] TL_GET              = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [31:0] d_data;
    } tilelink_d;

endpackage

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets (word index),
// STATUS bit positions and the transmitter state encoding.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_EMPTY  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_BUSY   = 2;
    localparam int ST_TX_OVF    = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_FRAME_ERR = 5;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO for bus peripherals. A push while full is accepted only when
// a pop happens in the same cycle, so occupancy stays unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tilelink_uart.sv
// Memory-mapped 8N1 serial port on the TileLink-UL data bus with a TX FIFO.
// Define UART_RX_EN to build the receiver and its one-byte holding register.
module tilelink_uart
    import tilelink_pkg::*;
    import uart_pkg::*;
#(
    parameter logic [31:0] addr_mask    = 32'hF0000000,
    parameter logic [31:0] addr_tag     = 32'h40000000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          TX_DEPTH     = 8
) (
    input  logic      clock,
    input  logic      reset_n,
    input  tilelink_a tick_tla,
    output tilelink_d bus_tld,
    output logic      serial_tx,
    input  logic      serial_rx,
    output logic      irq
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    logic        hit, is_get, wr_en, rd_en;
    logic [1:0]  offset;
    logic [31:0] rd_data;
    logic [5:0]  status;

    logic        tx_push, tx_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_data;
    logic [1:0]  tx_state;
    logic [BW-1:0] tx_baud;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_baud_end, tx_shift_en;
    logic        tx_busy, tx_empty;

    logic        tx_ovf, tx_irq_en;
    logic        clr_ovf, clr_overrun, clr_frame_err, ctrl_wr;
    logic        rx_valid, overrun, frame_err;
    logic [7:0]  rx_byte;
    logic        unused_bus;

    assign hit     = tick_tla.a_valid && ((tick_tla.a_address & addr_mask) == addr_tag);
    assign is_get  = (tick_tla.a_opcode == TL_GET);
    assign offset  = tick_tla.a_address[3:2];
    assign wr_en   = hit && !is_get;
    assign rd_en   = hit && is_get;

    assign tx_push       = wr_en && (offset == REG_TXDATA) && tick_tla.a_mask[0];
    assign ctrl_wr       = wr_en && (offset == REG_CTRL) && tick_tla.a_mask[0];
    assign clr_ovf       = wr_en && (offset == REG_STATUS) && tick_tla.a_mask[0] && tick_tla.a_data[ST_TX_OVF];
    assign clr_overrun   = wr_en && (offset == REG_STATUS) && tick_tla.a_mask[0] && tick_tla.a_data[ST_OVERRUN];
    assign clr_frame_err = wr_en && (offset == REG_STATUS) && tick_tla.a_mask[0] && tick_tla.a_data[ST_FRAME_ERR];
    assign unused_bus    = ^{tick_tla.a_data[31:8], tick_tla.a_mask[3:1]};

    assign tx_busy = (tx_state != TX_IDLE);
    assign tx_empty = fifo_empty && !tx_busy;

    always_comb begin
        status               = '0;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_FULL]   = fifo_full;
        status[ST_TX_BUSY]   = tx_busy;
        status[ST_TX_OVF]    = tx_ovf;
        status[ST_OVERRUN]   = overrun;
        status[ST_FRAME_ERR] = frame_err;
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            REG_RXDATA: rd_data = {23'b0, rx_valid, rx_byte};
            REG_STATUS: rd_data = {26'b0, status};
            REG_CTRL:   rd_data = {31'b0, tx_irq_en};
            default:    rd_data = '0;
        endcase
    end

    // Response stage: one-cycle ack for every hit, never stalls the bus
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_tld <= '0;
        end else begin
            bus_tld.d_valid  <= hit;
            bus_tld.d_opcode <= rd_en ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
            bus_tld.d_data   <= rd_en ? rd_data : 32'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf    <= 1'b0;
            tx_irq_en <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (tx_push && fifo_full && !tx_pop) tx_ovf <= 1'b1;
            else if (clr_ovf)                    tx_ovf <= 1'b0;
            if (ctrl_wr) tx_irq_en <= tick_tla.a_data[0];
            irq <= rx_valid || (tx_empty && tx_irq_en);
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (tx_push),
        .push_data (tick_tla.a_data[7:0]),
        .pop       (tx_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Popping at the end of STOP chains frames with no idle gap
    assign tx_baud_end = (tx_baud == BW'(CLKS_PER_BIT - 1));
    assign tx_pop      = !fifo_empty && ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_baud_end));
    assign tx_shift_en = tx_baud_end && ((tx_state == TX_START) || (tx_state == TX_DATA));

    always_ff @(posedge clock) begin
        if (tx_pop)           tx_shift <= fifo_data;
        else if (tx_shift_en) tx_shift <= {1'b0, tx_shift[7:1]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state  <= TX_IDLE;
            tx_baud   <= '0;
            tx_bit    <= '0;
            serial_tx <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_baud <= '0;
                    if (tx_pop) begin
                        tx_state  <= TX_START;
                        serial_tx <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_baud_end) begin
                        tx_baud   <= '0;
                        tx_bit    <= '0;
                        tx_state  <= TX_DATA;
                        serial_tx <= tx_shift[0];
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_baud_end) begin
                        tx_baud <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state  <= TX_STOP;
                            serial_tx <= 1'b1;
                        end else begin
                            tx_bit    <= tx_bit + 1'b1;
                            serial_tx <= tx_shift[0];
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                default: begin
                    if (tx_baud_end) begin
                        tx_baud <= '0;
                        if (tx_pop) begin
                            tx_state  <= TX_START;
                            serial_tx <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef UART_RX_EN
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic          rx_s1, rx_s2, rx_s3;
    logic [1:0]    rx_state;
    logic [BW-1:0] rx_baud;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_clear, rx_baud_end;

    assign rx_clear    = rd_en && (offset == REG_RXDATA);
    assign rx_baud_end = (rx_baud == BW'(CLKS_PER_BIT - 1));

    // A byte landing in the same cycle as the clearing read wins (later assignment)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_s3     <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_baud   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1 <= serial_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (rx_clear)      rx_valid  <= 1'b0;
            if (clr_overrun)   overrun   <= 1'b0;
            if (clr_frame_err) frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_baud <= '0;
                    if (rx_s3 && !rx_s2) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_baud == BW'(HALF - 1)) begin
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud_end) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
                default: begin
                    if (rx_baud_end) begin
                        rx_baud  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                            if (rx_valid && !rx_clear) overrun <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_baud <= rx_baud + 1'b1;
                    end
                end
            endcase
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^{serial_rx, clr_overrun, clr_frame_err};
    assign rx_valid  = 1'b0;
    assign rx_byte   = 8'h00;
    assign overrun   = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_tilelink_uart.sv
// Scoreboard bench for tilelink_uart: bus responses and the serial line are
// predicted when a request is driven and compared when the DUT produces them.
`timescale 1ns/1ps
module tb_tilelink_uart;
    import tilelink_pkg::*;

    localparam int CPB = 4;

    logic      clock = 1'b0;
    logic      reset_n;
    tilelink_a tla;
    tilelink_d tld;
    logic      serial_tx;
    logic      serial_rx;
    logic      irq;
    logic      loop_en;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [2:0]  op;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int   due;
        logic val;
    } line_t;

    resp_t rq[$];
    line_t lq[$];

    assign serial_rx = loop_en ? serial_tx : 1'b1;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    tilelink_uart #(
        .addr_mask    (32'hF0000000),
        .addr_tag     (32'h40000000),
        .CLKS_PER_BIT (CPB),
        .TX_DEPTH     (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tick_tla  (tla),
        .bus_tld   (tld),
        .serial_tx (serial_tx),
        .serial_rx (serial_rx),
        .irq       (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at posedge+#1; request is live for exactly one cycle
    task automatic bus_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic exp_hit, input logic [31:0] exp_data);
        tla.a_valid   = 1'b1;
        tla.a_opcode  = op;
        tla.a_address = addr;
        tla.a_mask    = 4'hF;
        tla.a_data    = data;
        if (exp_hit) begin
            if (op == TL_GET) rq.push_back('{due: cyc + 1, op: TL_ACCESS_ACK_DATA, data: exp_data});
            else              rq.push_back('{due: cyc + 1, op: TL_ACCESS_ACK, data: 32'h0});
        end
        @(posedge clock); #1;
        tla = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_frame(input int start, input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int k = 0; k < 10 * CPB + 4; k++)
            lq.push_back('{due: start + k, val: (k < 10 * CPB) ? frame[k / CPB] : 1'b1});
    endtask

    always @(negedge clock) begin : monitor
        resp_t r;
        line_t l;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            check_eq("d_valid", 32'(tld.d_valid), 32'h1);
            check_eq("d_opcode", 32'(tld.d_opcode), 32'(r.op));
            check_eq("d_data", tld.d_data, r.data);
        end else if (tld.d_valid) begin
            check_eq("spurious_d_valid", 32'(tld.d_valid), 32'h0);
        end
        if (lq.size() > 0 && lq[0].due == cyc) begin
            l = lq.pop_front();
            check_eq("serial_tx", 32'(serial_tx), 32'(l.val));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        tla     = '0;
        loop_en = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_d_valid", 32'(tld.d_valid), 32'h0);
        check_eq("rst_d_data", tld.d_data, 32'h0);
        check_eq("rst_serial_tx", 32'(serial_tx), 32'h1);
        check_eq("rst_irq", 32'(irq), 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(1);

        // Reset state via STATUS and CTRL
        bus_req(TL_GET, 32'h40000008, 32'h0, 1'b1, 32'h1);
        bus_req(TL_GET, 32'h4000000C, 32'h0, 1'b1, 32'h0);
        bus_req(TL_GET, 32'h40000000, 32'h0, 1'b1, 32'h0);
        idle(2);

        // Single byte 0x55: line shape checked cycle by cycle
        expect_frame(cyc + 2, 8'h55);
        bus_req(TL_PUT_FULL_DATA, 32'h40000000, 32'h55, 1'b1, 32'h0);
        idle(10 * CPB + 6);

        // Overflow: FSM busy, 9 pushes into an empty FIFO of 8
        bus_req(TL_PUT_FULL_DATA, 32'h40000000, 32'h11, 1'b1, 32'h0);
        idle(3);
        for (int i = 0; i < 9; i++)
            bus_req(TL_PUT_FULL_DATA, 32'h40000000, 32'(8'h20 + i), 1'b1, 32'h0);
        bus_req(TL_GET, 32'h40000008, 32'h0, 1'b1, 32'h0E);
        bus_req(TL_PUT_FULL_DATA, 32'h40000008, 32'h8, 1'b1, 32'h0);
        bus_req(TL_GET, 32'h40000008, 32'h0, 1'b1, 32'h06);
        bus_req(TL_PUT_FULL_DATA, 32'h4000000C, 32'h1, 1'b1, 32'h0);
        bus_req(TL_GET, 32'h4000000C, 32'h0, 1'b1, 32'h1);
        @(negedge clock);
        check_eq("irq_while_busy", 32'(irq), 32'h0);
        @(posedge clock); #1;
        idle(9 * 10 * CPB + 20);
        bus_req(TL_GET, 32'h40000008, 32'h0, 1'b1, 32'h1);
        @(negedge clock);
        check_eq("irq_tx_empty", 32'(irq), 32'h1);
        @(posedge clock); #1;

        // Miss: no response and nothing queued for transmit
        bus_req(TL_PUT_FULL_DATA, 32'h80000000, 32'hAA, 1'b0, 32'h0);
        @(negedge clock);
        check_eq("miss_d_valid", 32'(tld.d_valid), 32'h0);
        @(posedge clock); #1;
        bus_req(TL_GET, 32'h40000008, 32'h0, 1'b1, 32'h1);
        idle(2);

        // Reset asserted during DATA of a 0x00 frame
        bus_req(TL_PUT_FULL_DATA, 32'h40000000, 32'h00, 1'b1, 32'h0);
        bus_req(TL_PUT_FULL_DATA, 32'h40000000, 32'h00, 1'b1, 32'h0);
        idle(8);
        @(negedge clock);
        check_eq("pre_reset_line", 32'(serial_tx), 32'h0);
        reset_n = 1'b0;
        #1;
        check_eq("mid_reset_serial_tx", 32'(serial_tx), 32'h1);
        check_eq("mid_reset_d_valid", 32'(tld.d_valid), 32'h0);
        check_eq("mid_reset_irq", 32'(irq), 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) lq.push_back('{due: cyc + k, val: 1'b1});
        bus_req(TL_GET, 32'h40000008, 32'h0, 1'b1, 32'h1);
        bus_req(TL_GET, 32'h4000000C, 32'h0, 1'b1, 32'h0);
        idle(8);

`ifdef UART_RX_EN
        // Loopback receive of 0xA3
        loop_en = 1'b1;
        idle(2);
        bus_req(TL_PUT_FULL_DATA, 32'h40000000, 32'hA3, 1'b1, 32'h0);
        idle(10 * CPB + 20);
        @(negedge clock);
        check_eq("irq_rx_valid", 32'(irq), 32'h1);
        @(posedge clock); #1;
        bus_req(TL_GET, 32'h40000004, 32'h0, 1'b1, 32'h1A3);
        bus_req(TL_GET, 32'h40000004, 32'h0, 1'b1, 32'h0A3);
        bus_req(TL_GET, 32'h40000008, 32'h0, 1'b1, 32'h1);
        idle(3);
        @(negedge clock);
        check_eq("irq_rx_cleared", 32'(irq), 32'h0);
        @(posedge clock); #1;
        loop_en = 1'b0;
`endif

        idle(3);
        check_eq("resp_queue_drained", 32'(rq.size()), 32'h0);
        check_eq("line_queue_drained", 32'(lq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
